// File: rtl/uart_rx_word24.sv
// rtl/uart_rx_word24.sv - 8N1 UART receiver that packs three bytes into one 24-bit word (MSB byte first).
// Define RX_TIMEOUT_EN to drop a partial word after TIMEOUT_BITS idle bit times.
module uart_rx_word24 #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RxD,
  output logic [23:0] data,
  output logic        valid,
  output logic        busy,
  output logic        frame_err,
  output logic        rx_timeout
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t            state_q, state_d;
  logic              rx_meta_q, rxs_q;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        byte0_q, byte0_d;
  logic [7:0]        byte1_q, byte1_d;
  logic [23:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              timeout_q, timeout_d;

`ifdef RX_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  // RxD is asynchronous; only the second stage is ever looked at
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= RxD;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      byte0_q     <= '0;
      byte1_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    timeout_d   = 1'b0;
`ifdef RX_TIMEOUT_EN
    idle_d      = '0;
`endif

    case (state_q)
      IDLE: begin
        // start detection has priority over an expiring timeout
        if (!rxs_q) begin
          baud_d  = '0;
          state_d = START;
`ifdef RX_TIMEOUT_EN
        end else if (idx_q != 2'd0) begin
          if (idle_q == IDLE_LAST) begin
            timeout_d = 1'b1;
            idx_d     = 2'd0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
`endif
        end
      end

      START: begin
        if (baud_q == BAUD_MID) begin
          baud_d = '0;
          bit_d  = '0;
          if (rxs_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (rxs_q) begin
            state_d = IDLE;
            case (idx_q)
              2'd0: begin
                byte0_d = shift_q;
                idx_d   = 2'd1;
              end
              2'd1: begin
                byte1_d = shift_q;
                idx_d   = 2'd2;
              end
              default: begin
                data_d  = {byte0_q, byte1_q, shift_q};
                valid_d = 1'b1;
                idx_d   = 2'd0;
              end
            endcase
          end else begin
            frame_err_d = 1'b1;
            idx_d       = 2'd0;
            state_d     = WAIT_HIGH;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      // a held-low line (break) must not be re-read as a stream of start bits
      WAIT_HIGH: begin
        if (rxs_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE) || (idx_q != 2'd0);

`ifdef RX_TIMEOUT_EN
  assign rx_timeout = timeout_q;
`else
  // timeout logic is compiled out; the register is never set
  assign rx_timeout = timeout_q && (TIMEOUT_BITS > 0);
`endif

endmodule

// File: tb/tb_uart_rx_word24.sv
// tb/tb_uart_rx_word24.sv - directed self-checking bench for uart_rx_word24 at 16 clocks per bit.
module tb_uart_rx_word24;

  localparam int BIT = 16;

  logic        clk;
  logic        reset;
  logic        RxD;
  logic [23:0] data;
  logic        valid;
  logic        busy;
  logic        frame_err;
  logic        rx_timeout;

  int          checks = 0;
  int          errors = 0;
  int          vcnt = 0;
  int          fcnt = 0;
  int          tcnt = 0;
  logic [23:0] cap [0:15];

  uart_rx_word24 #(
    .CLKS_PER_BIT(BIT),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .RxD        (RxD),
    .data       (data),
    .valid      (valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .rx_timeout (rx_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      if (vcnt < 16) cap[vcnt] = data;
      vcnt++;
    end
    if (frame_err) fcnt++;
    if (rx_timeout) tcnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bit_time();
    repeat (BIT) @(posedge clk);
    #2;
  endtask

  task automatic idle_bits(input int n);
    RxD = 1'b1;
    repeat (n) bit_time();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    RxD = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      bit_time();
    end
    RxD = stop;
    bit_time();
  endtask

  initial begin
    reset = 1'b1;
    RxD   = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_data", {8'h0, data}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_timeout", {31'h0, rx_timeout}, 32'h0);
    reset = 1'b0;
    idle_bits(2);

    // back-to-back word
    send_frame(8'h41, 1'b1);
    check("partial_busy", {31'h0, busy}, 32'h1);
    send_frame(8'h42, 1'b1);
    send_frame(8'h43, 1'b1);
    idle_bits(1);
    check("w1_count", vcnt, 1);
    check("w1_cap", {8'h0, cap[0]}, 32'h00414243);
    check("w1_data", {8'h0, data}, 32'h00414243);
    check("w1_busy", {31'h0, busy}, 32'h0);
    check("w1_ferr", fcnt, 0);

    // two words with 3 idle bits between bytes
    send_frame(8'hAA, 1'b1); idle_bits(3);
    send_frame(8'h55, 1'b1); idle_bits(3);
    send_frame(8'h00, 1'b1); idle_bits(3);
    send_frame(8'h01, 1'b1); idle_bits(3);
    send_frame(8'hFF, 1'b1); idle_bits(3);
    send_frame(8'h80, 1'b1); idle_bits(3);
    check("w23_count", vcnt, 3);
    check("w2_cap", {8'h0, cap[1]}, 32'h00AA5500);
    check("w3_cap", {8'h0, cap[2]}, 32'h0001FF80);

    // 5-cycle glitch is a false start
    RxD = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    RxD = 1'b1;
    check("glitch_busy_start", {31'h0, busy}, 32'h1);
    idle_bits(2);
    check("glitch_busy_idle", {31'h0, busy}, 32'h0);
    check("glitch_valid", vcnt, 3);
    check("glitch_ferr", fcnt, 0);

    // good byte then a bad stop bit: partial word is discarded
    send_frame(8'h77, 1'b1);
    send_frame(8'h12, 1'b0);
    repeat (2) bit_time();
    check("ferr_count", fcnt, 1);
    check("ferr_wait_busy", {31'h0, busy}, 32'h1);
    check("ferr_data_held", {8'h0, data}, 32'h0001FF80);
    idle_bits(1);
    check("ferr_busy_clear", {31'h0, busy}, 32'h0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    idle_bits(1);
    check("w4_count", vcnt, 4);
    check("w4_data", {8'h0, data}, 32'h00112233);

    // async reset in the middle of the second byte's data bits
    send_frame(8'h01, 1'b1);
    RxD = 1'b0;
    bit_time();
    RxD = 1'b0;
    bit_time();
    RxD = 1'b1;
    bit_time();
    #1;
    reset = 1'b1;
    #1;
    check("arst_data", {8'h0, data}, 32'h0);
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_valid", {31'h0, valid}, 32'h0);
    RxD = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    idle_bits(1);
    send_frame(8'h0A, 1'b1);
    send_frame(8'h0B, 1'b1);
    send_frame(8'h0C, 1'b1);
    idle_bits(1);
    check("w5_count", vcnt, 5);
    check("w5_cap", {8'h0, cap[4]}, 32'h000A0B0C);

    // long gap after one byte
    send_frame(8'h55, 1'b1);
    idle_bits(25);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    idle_bits(1);
    check("w6_count", vcnt, 6);
`ifdef RX_TIMEOUT_EN
    check("to_count", tcnt, 1);
    check("to_data", {8'h0, data}, 32'h00010203);
    check("to_busy", {31'h0, busy}, 32'h0);
`else
    check("to_count", tcnt, 0);
    check("to_data", {8'h0, data}, 32'h00550102);
    check("to_busy", {31'h0, busy}, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
